// File: rtl/temp_ascii_framer_pkg.sv
// temp_fmt_pkg: shared constants for the temperature ASCII framer.
//   ASCII characters used in the output line and the framer FSM encoding.
//   digit_char() maps a BCD nibble to its ASCII digit.
package temp_fmt_pkg;

  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/temp_ascii_framer_if.sv
// temp_ascii_framer_if: byte stream from the framer to a byte-wide UART.
//   byte_data  ASCII byte
//   byte_valid byte_data is valid
//   byte_ready sink accepts byte_data this cycle
//   master = framer side, slave = UART side.
interface temp_ascii_framer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, byte_valid, input byte_ready);
  modport slave  (input byte_data, byte_valid, output byte_ready);
endinterface

// File: rtl/temp_ascii_framer_bcd.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk, rst  clock, synchronous active-high reset
//   load      capture bin_in and start a conversion (DATA_WIDTH cycles)
//   bin_in    unsigned binary input
//   bcd       BCD_DIGITS nibbles, least significant digit in bcd[3:0]
//   done      high during the cycle of the final shift; bcd holds the
//             finished result from the next cycle until the next load
module bin2bcd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   bin_in,
  output logic [BCD_DIGITS*4-1:0] bcd,
  output logic                    done
);
  localparam int BW = BCD_DIGITS * 4;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] sh;
  logic [CW-1:0]         cnt;
  logic                  run;
  logic [BW-1:0]         adj;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      sh  <= bin_in;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, sh} <= {adj[BW-2:0], sh, 1'b0};
      cnt       <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  assign done = run && (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/temp_ascii_framer.sv
// temp_ascii_framer: formats one temperature sample as "+DDD.DD" plus a
// line terminator and streams it one byte per handshake.
//   clk        system clock
//   rst        synchronous active-high reset, aborts any line in progress
//   start      1-cycle request, accepted only in IDLE
//   temp_data  |T| x 100, captured on an accepted start
//   sign       1 = negative, captured with temp_data
//   busy       high from the cycle after an accepted start to the end of line
//   tx         byte stream (master): byte_data / byte_valid / byte_ready
// Build option: define TEMP_ASCII_FRAMER_CRLF_EN for a CR LF terminator,
// otherwise the line ends with LF only.
module temp_ascii_framer
  import temp_fmt_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BCD_DIGITS  = 5,
  parameter int FRAC_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] temp_data,
  input  logic                  sign,
  output logic                  busy,
  temp_ascii_framer_if.master   tx
);
  localparam int INT_DIGITS = BCD_DIGITS - FRAC_DIGITS;
`ifdef TEMP_ASCII_FRAMER_CRLF_EN
  localparam int LINE_LEN = BCD_DIGITS + 4;
`else
  localparam int LINE_LEN = BCD_DIGITS + 3;
`endif
  localparam int CW = $clog2(LINE_LEN);

  state_t                  state, state_nx;
  logic [CW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   mag;
  logic                    neg;
  logic [BCD_DIGITS*4-1:0] bcd;
  logic                    conv_done;
  logic                    load;
  logic                    xfer;
  logic                    last;

  assign load = (state == IDLE) && start;
  assign xfer = tx.byte_valid && tx.byte_ready;
  assign last = (idx == CW'(LINE_LEN - 1));

  bin2bcd_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bin_in(temp_data),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // conv_done marks the final shift, so EMIT starts exactly as bcd settles.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)        state_nx = CONVERT;
      CONVERT: if (conv_done)    state_nx = EMIT;
      EMIT:    if (xfer && last) state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag <= '0;
      neg <= 1'b0;
    end else if (load) begin
      mag <= temp_data;
      neg <= sign;
    end
  end

  // Byte index only moves on a transfer, which keeps byte_data stable
  // through stalls; it is held at 0 outside EMIT.
  always_ff @(posedge clk) begin
    if (rst || state != EMIT) idx <= '0;
    else if (xfer)            idx <= idx + 1'b1;
  end

  assign busy          = (state != IDLE);
  assign tx.byte_valid = (state == EMIT);

  // Layout: sign, INT_DIGITS digits, '.', FRAC_DIGITS digits, terminator.
  always_comb begin
    tx.byte_data = 8'h00;
    if (state == EMIT) begin
      if (idx == '0) begin
        tx.byte_data = (neg && mag != '0) ? MINUS : PLUS;
      end else if (int'(idx) == INT_DIGITS + 1) begin
        tx.byte_data = DOT;
      end else if (int'(idx) >= BCD_DIGITS + 2) begin
`ifdef TEMP_ASCII_FRAMER_CRLF_EN
        tx.byte_data = (int'(idx) == BCD_DIGITS + 2) ? CR : LF;
`else
        tx.byte_data = LF;
`endif
      end
      // digit k counts from the most significant; fraction digits sit one
      // position further right because of the '.'
      for (int k = 0; k < BCD_DIGITS; k++) begin
        if (int'(idx) == ((k < INT_DIGITS) ? k + 1 : k + 2))
          tx.byte_data = digit_char(bcd[(BCD_DIGITS-1-k)*4 +: 4]);
      end
    end
  end

endmodule
